// File: rtl/dcim_top.sv
// rtl/dcim_top.sv - 8-row bit-serial digital compute-in-memory dot-product engine.
// Define DCIM_SIGNED_EN for two's complement inputs/weights; default build is unsigned.
module dcim_top (
    input  logic         clk,
    input  logic         rstn,
    input  logic [23:0]  D,
    input  logic [7:0]   WA,
    input  logic         acm_en,
    input  logic         cima,
    input  logic         inwidth,
    input  logic         wwidth,
    input  logic         start,
    input  logic [191:0] xin0,
    output logic [50:0]  nout,
    output logic         st
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [23:0] w   [8];
    logic [23:0] x_l [8];
    logic        inw_l;
    logic        ww_l;
    logic        cima_l;
    logic [4:0]  cnt;
    logic [50:0] acc;
    logic [50:0] psum;
    logic        msb_cycle;

    function automatic logic [50:0] wext(input logic [23:0] wr, input logic wide);
`ifdef DCIM_SIGNED_EN
        wext = wide ? {{27{wr[23]}}, wr} : {{39{wr[11]}}, wr[11:0]};
`else
        wext = wide ? {27'd0, wr} : {39'd0, wr[11:0]};
`endif
    endfunction

    always_comb begin
        psum = '0;
        for (int i = 0; i < 8; i++) begin
            if (x_l[i][cnt]) psum = psum + wext(w[i], ww_l);
        end
    end

    assign msb_cycle = (cnt == (inw_l ? 5'd23 : 5'd11));

    // The product accumulates from zero; the previous nout is folded in at DONE,
    // which equals preloading it without it being scaled by the bit shifts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                w[i]   <= '0;
                x_l[i] <= '0;
            end
            inw_l  <= 1'b0;
            ww_l   <= 1'b0;
            cima_l <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            nout   <= '0;
            st     <= 1'b0;
        end else begin
            st <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acm_en && !cima) begin
                        for (int i = 0; i < 8; i++) begin
                            if (WA[i]) w[i] <= D;
                        end
                    end
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            x_l[i] <= inwidth ? xin0[24*i +: 24] : {12'd0, xin0[24*i +: 12]};
                        end
                        inw_l  <= inwidth;
                        ww_l   <= wwidth;
                        cima_l <= cima;
                        cnt    <= inwidth ? 5'd23 : 5'd11;
                        acc    <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
`ifdef DCIM_SIGNED_EN
                    acc <= msb_cycle ? ((acc << 1) - psum) : ((acc << 1) + psum);
`else
                    acc <= (acc << 1) + psum;
`endif
                    if (cnt == 5'd0) state <= S_DONE;
                    else             cnt   <= cnt - 5'd1;
                end
                S_DONE: begin
                    nout  <= acc + (cima_l ? nout : 51'd0);
                    st    <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef DCIM_SIGNED_EN
    logic unused_msb;
    assign unused_msb = msb_cycle;
`endif

endmodule

// File: tb/tb_dcim_top.sv
// tb/tb_dcim_top.sv - scoreboard bench for dcim_top with a dot-product reference model.
module tb_dcim_top;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [23:0]  D = '0;
    logic [7:0]   WA = '0;
    logic         acm_en = 1'b0;
    logic         cima = 1'b0;
    logic         inwidth = 1'b0;
    logic         wwidth = 1'b0;
    logic         start = 1'b0;
    logic [191:0] xin0 = '0;
    logic [50:0]  nout;
    logic         st;

    dcim_top dut (
        .clk(clk), .rstn(rstn), .D(D), .WA(WA), .acm_en(acm_en), .cima(cima),
        .inwidth(inwidth), .wwidth(wwidth), .start(start), .xin0(xin0),
        .nout(nout), .st(st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [50:0] val;
        int          due;
    } exp_t;
    exp_t sbq[$];

    logic [23:0] mw [8];
    logic [50:0] mn;

    function automatic longint sval(input logic [23:0] v, input bit wide);
        longint r;
        r = wide ? longint'(v) : longint'(v[11:0]);
`ifdef DCIM_SIGNED_EN
        if (wide && v[23])       r = r - 64'sd16777216;
        else if (!wide && v[11]) r = r - 64'sd4096;
`endif
        return r;
    endfunction

    function automatic logic [50:0] model_dot(input logic [191:0] x, input bit inw, input bit ww);
        longint s = 0;
        for (int i = 0; i < 8; i++) s += sval(x[24*i +: 24], inw) * sval(mw[i], ww);
        return 51'(s);
    endfunction

    task automatic chk(input string nm, input logic [50:0] act, input logic [50:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && st) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_st: st high at cycle %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (nout !== e.val || cyc != e.due) begin
                    fails++;
                    $display("FAIL result: nout=%h at cycle %0d, expected %h at cycle %0d",
                             nout, cyc, e.val, e.due);
                end
            end
        end
    end

    task automatic write_w(input logic [23:0] d, input logic [7:0] wa);
        @(negedge clk);
        D = d; WA = wa; acm_en = 1'b1; cima = 1'b0;
        @(negedge clk);
        acm_en = 1'b0; WA = '0;
        for (int i = 0; i < 8; i++) if (wa[i]) mw[i] = d;
    endtask

    task automatic issue(input logic [191:0] x, input bit inw, input bit ww, input bit cm);
        logic [50:0] e;
        int n;
        n = inw ? 24 : 12;
        @(negedge clk);
        e = model_dot(x, inw, ww) + (cm ? mn : 51'd0);
        mn = e;
        sbq.push_back('{e, cyc + n + 2});
        xin0 = x; inwidth = inw; wwidth = ww; cima = cm; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cima = 1'b0;
        xin0 = {6{$urandom}};
    endtask

    task automatic wait_done();
        int t = 0;
        while (sbq.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: no st within 60 cycles, %0d pending", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic compute(input logic [191:0] x, input bit inw, input bit ww, input bit cm,
                           input bit poke);
        issue(x, inw, ww, cm);
        if (poke) begin
            @(negedge clk);
            start = 1'b1; acm_en = 1'b1; cima = 1'b0;
            WA = 8'($urandom_range(1, 255)); D = 24'($urandom);
            @(negedge clk);
            start = 1'b0; acm_en = 1'b0; WA = '0;
        end
        wait_done();
    endtask

    function automatic logic [191:0] rand_x();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mw[i] = '0;
        mn = '0;
        repeat (3) @(negedge clk);
        chk("reset_nout", nout, 51'd0);
        chk("reset_st", {50'd0, st}, 51'd0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) write_w(24'(i + 1), 8'(1 << i));
        compute('1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("dot12_const", nout, 51'h23FDC);
        compute('1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("accum_const", nout, 51'h47FB8);
        compute('1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("dot24_const", nout, 51'h23FFFFDC);

        write_w(24'd0, 8'hFE);
        write_w(24'hFFF001, 8'h01);
        compute(192'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        compute(192'h2, 1'b0, 1'b1, 1'b0, 1'b0);
`ifndef DCIM_SIGNED_EN
        chk("mask_w24", nout, 51'h1FFE002);
`endif

        write_w(24'h000005, 8'h03);
        compute({{6{24'd0}}, 24'd3, 24'd7}, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DCIM_SIGNED_EN
        write_w(24'h000FFF, 8'h01);
        write_w(24'd0, 8'hFE);
        compute(192'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("signed_neg2", nout, 51'h7FFFFFFFFFFFE);
`endif

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) write_w(24'($urandom), 8'($urandom));
            compute(rand_x(), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        issue(rand_x(), 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midbusy_reset_nout", nout, 51'd0);
        chk("midbusy_reset_st", {50'd0, st}, 51'd0);
        sbq.delete();
        mn = '0;
        for (int i = 0; i < 8; i++) mw[i] = '0;
        @(negedge clk);
        rstn = 1'b1;
        compute(rand_x(), 1'b1, 1'b1, 1'b0, 1'b0);
        chk("zero_weights", nout, 51'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcim_top.md
DCIM_TOP -- requirements
Module: dcim_top

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port D  input  24  weight write data.
REQ-004 SHALL have port WA  input  8  one-hot row write-select; bit i selects weight row i.
REQ-005 SHALL have port acm_en  input  1  array write enable.
REQ-006 SHALL have port cima  input  1  1 = compute accumulates onto previous nout; 0 = write-permit / fresh result.
REQ-007 SHALL have port inwidth  input  1  input precision: 0 = 12-bit, 1 = 24-bit.
REQ-008 SHALL have port wwidth  input  1  weight precision: 0 = 12-bit (w[11:0]), 1 = 24-bit.
REQ-009 SHALL have port start  input  1  compute request, sampled on rising clk.
REQ-010 SHALL have port xin0  input  192  eight activations; x_i = xin0[24i+23:24i].
REQ-011 SHALL have port nout  output  51  dot-product result, registered.
REQ-012 SHALL have port st  output  1  done pulse, registered.

Function
REQ-013 SHALL hold eight 24-bit weight rows w_0..w_7.
REQ-014 SHALL write D into every row i with WA[i]=1 on a rising edge when acm_en=1, cima=0 and the block is idle; WA=0 writes nothing; writes while busy are ignored.
REQ-015 SHALL, when idle and start=1 at a rising edge, latch xin0, inwidth, wwidth, cima and enter BUSY; start while BUSY is ignored.
REQ-016 SHALL mask each latched x_i to 12 bits (x_i[11:0]) when inwidth=0, weights to w_i[11:0] when wwidth=0.
REQ-017 SHALL process inputs bit-serially MSB first, N = 12 (inwidth=0) or 24 (inwidth=1) cycles: acc = (acc<<1) + sum over i of (x_i[b] ? w_i : 0).
REQ-018 SHALL clear acc at start when latched cima=0, preload acc with current nout when latched cima=1; arithmetic modulo 2^51.
REQ-019 SHALL, in the cycle after the last bit cycle (start edge + N+1 edges), load nout with acc, assert st for exactly one cycle, and return to IDLE.
REQ-020 SHALL hold nout stable between completions; st=0 except the done cycle.
REQ-021 SHALL use states IDLE -> BUSY (N cycles) -> DONE (1 cycle) -> IDLE; a start sampled in DONE is ignored.
REQ-022 SHALL treat weights and inputs as unsigned by default; result = sum x_i*w_i (max 8*(2^24-1)^2 < 2^51).

Reset
REQ-023 SHALL, on rstn=0 at any time, asynchronously clear all weight rows, acc, nout to 0, st to 0, state to IDLE, aborting any computation.
REQ-024 SHALL accept writes and start from the first rising edge after rstn deasserts.

Configuration
REQ-025 SHALL, when macro DCIM_SIGNED_EN is defined, treat masked x_i and w_i as two's complement at their selected width (MSB input bit cycle subtracts the partial sum) and nout as 51-bit two's complement.
REQ-026 SHALL, when DCIM_SIGNED_EN is undefined, implement unsigned arithmetic only, per REQ-022.

Verification
REQ-027 SHALL verify reset: rstn=0 mid-BUSY -> nout=0, st=0 immediately; subsequent start with zero weights -> nout=0.
REQ-028 SHALL verify 12-bit compute: write rows 0..7 = 1..8 via WA=01,02,..,80; xin0=all ones, inwidth=0, wwidth=0, start 1 cycle -> st high exactly 13 edges after start edge, nout=51'h23FDC (36*4095).
REQ-029 SHALL verify 24-bit compute: same weights, inwidth=1, wwidth=1, xin0=all ones -> st after 25 edges, nout=36*16777215=51'h23FFFFDC.
REQ-030 SHALL verify masking: w_0=24'hFFF001 only, x_0=24'h000002, others 0, wwidth=0, inwidth=0 -> nout=51'h2; wwidth=1 -> nout=51'h1FFE002.
REQ-031 SHALL verify accumulate and guards: repeat REQ-028 with cima=1 -> nout=51'h47FB8; start and writes during BUSY ignored; WA=8'h03 writes rows 0 and 1.
REQ-032 SHALL verify DCIM_SIGNED_EN: w_0=12'hFFF (-1), x_0=12'h002, others 0, 12-bit mode -> nout=51'h7FFFFFFFFFFFE (-2).
